pci_defsm_addr_decode: RTL
==========================

// Module: pci_defsm_addr_decode
// PURPOSE
//  Upstream dispatch stage of the PCI target decode FSM. Detects the PCI address
//  phase, latches address and command, and classifies the transaction: Type-0 config
//  goes to the interrupt/config manager, BAR0 memory goes to the memory handler.
//  Issues a one-cycle start pulse to the selected handler, waits for its end pulse,
//  then waits for bus idle. Unclaimed transactions are ignored (no DEVSEL).
// PARAMETERS
//  BAR0_SIZE_LOG2  12  BAR0 window size = 2**BAR0_SIZE_LOG2 bytes; valid range 4..31
//  TIMEOUT_CYC     64  max cycles in a WAIT_* state before abort; valid range 2..255
// PORTS
//  PHY_CLK33_I          in   1   33 MHz PCI clock
//  PHY_RSTn_I           in   1   asynchronous active-low reset
//  INT_FRAMEn_I         in   1   synchronised FRAME#
//  INT_IRDYn_I          in   1   synchronised IRDY#
//  INT_IDSEL_I          in   1   IDSEL for this slot
//  CFG_AD_I             in   32  AD bus input
//  CFG_CBEn_I           in   4   C/BE# input (command during address phase)
//  CFG_REG_0x04_MEM_EN_I in  1   Command register memory-space enable
//  BAR0_BASE_I          in   32  BAR0 value from config space
//  DEFSM_ADD2INTMNG_O   out  1   1-cycle start pulse to config/interrupt manager
//  DEFSM_INTMNG_END_I   in   1   end pulse from config/interrupt manager
//  DEFSM_ADD2MEM_O      out  1   1-cycle start pulse to memory handler
//  DEFSM_MEM_END_I      in   1   end pulse from memory handler
//  DEFSM_ADDR_O         out  32  latched address (stable until next address phase)
//  DEFSM_CMD_O          out  4   latched command
//  DEFSM_BUSY_O         out  1   high in every state except IDLE
//  DEFSM_ABORT_O        out  1   1-cycle pulse on handler timeout
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, frame_q=0. A transaction in flight at reset
//   release is not claimed until FRAMEn has been sampled high.
//  frame_q is a register holding the previous cycle's sampled FRAMEn.
//  Address phase (addr_ev) = IDLE && frame_q==1 && INT_FRAMEn_I==0. On that edge:
//   DEFSM_ADDR_O<=CFG_AD_I, DEFSM_CMD_O<=~CFG_CBEn_I, cfg_hit/mem_hit registered,
//   ->DECODE. FRAMEn falling edges outside IDLE are ignored.
//  cfg_hit = cmd in {1010,1011} && IDSEL && AD[1:0]==00.
//  mem_hit = cmd in {0110,0111,1100,1110,1111} && MEM_EN &&
//   AD[31:BAR0_SIZE_LOG2]==BAR0_BASE_I[31:BAR0_SIZE_LOG2].
//  cfg_hit and mem_hit are mutually exclusive by command. DAC (1101) and all other
//   commands are unclaimed.
//  States: IDLE, DECODE, WAIT_CFG, WAIT_MEM, IGNORE, TURNAROUND.
//   DECODE: cfg_hit -> ADD2INTMNG=1 for 1 cycle, ->WAIT_CFG;
//           mem_hit -> ADD2MEM=1 for 1 cycle, ->WAIT_MEM; else ->IGNORE.
//   Start pulse is registered and high in the 2nd cycle after the address phase.
//   WAIT_CFG: INTMNG_END_I -> TURNAROUND. WAIT_MEM: MEM_END_I -> TURNAROUND.
//   The end input of the non-selected handler is ignored.
//   WAIT_*: 8-bit tmo counter cleared on entry, +1 per cycle. When count reaches
//    TIMEOUT_CYC-1 without an end pulse -> ABORT_O=1 for 1 cycle, ->TURNAROUND.
//    End pulse and timeout in the same cycle: end wins, no abort.
//   IGNORE, TURNAROUND: ->IDLE when INT_FRAMEn_I==1 && INT_IRDYn_I==1.
//    The first addr_ev can occur the cycle after returning to IDLE.
//  Back-to-back: in IDLE, frame_q already holds 1 from the idle bus, so a new
//   FRAMEn fall is detected immediately.
//  Async reset mid-transaction: immediate return to reset values; no end or start
//   pulse is replayed.
// TESTING
//  1 Cfg read: IDSEL=1, CBEn=~1010, AD=0x0000_0004 -> ADD2INTMNG pulse 2 clk after
//    addr; CMD_O=1010, ADDR_O=4; END pulse, then FRAMEn/IRDYn high -> IDLE, BUSY=0.
//  2 Mem write: BAR0=0x8000_0000, MEM_EN=1, AD=0x8000_0ABC, cmd 0111 -> ADD2MEM
//    pulse; same AD with MEM_EN=0 -> IGNORE, no pulse.
//  3 Cfg cycle with IDSEL=0, or AD[1:0]=01 -> no start pulse; returns to IDLE when
//    the bus goes idle.
//  4 Handler silent: no END for 64 cycles -> ABORT_O pulse exactly 64 cycles after
//    entering WAIT; END on that same cycle -> no ABORT.
//  5 Back-to-back cfg transactions separated by 1 idle cycle -> both dispatched;
//    MEM_END during WAIT_CFG is ignored.
//  6 Reset asserted in WAIT_MEM with FRAMEn held low -> all outputs 0; no addr_ev
//    until FRAMEn has been sampled high.

Source files
------------

// File: rtl/pci_defsm_addr_decode.sv
// ---------------------------------------------------------------------------
// pci_defsm_addr_decode
//
// Upstream dispatch stage of the PCI target decode FSM. Watches for the PCI
// address phase (a FRAME# falling edge seen while idle), latches address and
// command, and classifies the transaction:
//   - Type-0 configuration cycle  -> config/interrupt manager
//   - memory cycle hitting BAR0   -> memory handler
//   - anything else               -> ignored (no DEVSEL is ever claimed)
// The selected handler gets a one-cycle start pulse. The FSM then waits for
// that handler's end pulse (bounded by a timeout), and finally waits for the
// bus to go idle before accepting a new address phase.
//
// Handshake: start and end are single-cycle pulses, with no ready side. A
// start is issued exactly once per claimed transaction. Only the end pulse
// of the selected handler is honoured, and only while waiting for it. A
// pulse on the other handler's end input, or one arriving in any other
// state, is dropped.
//
// Ports
//   PHY_CLK33_I            33 MHz PCI clock
//   PHY_RSTn_I             asynchronous active-low reset
//   INT_FRAMEn_I           synchronised FRAME#
//   INT_IRDYn_I            synchronised IRDY#
//   INT_IDSEL_I            IDSEL for this slot
//   CFG_AD_I[31:0]         AD bus
//   CFG_CBEn_I[3:0]        C/BE# (command during the address phase)
//   CFG_REG_0x04_MEM_EN_I  command register memory-space enable
//   BAR0_BASE_I[31:0]      BAR0 value from config space
//   DEFSM_ADD2INTMNG_O     start pulse to the config/interrupt manager
//   DEFSM_INTMNG_END_I     end pulse from the config/interrupt manager
//   DEFSM_ADD2MEM_O        start pulse to the memory handler
//   DEFSM_MEM_END_I        end pulse from the memory handler
//   DEFSM_ADDR_O[31:0]     latched address, held until the next address phase
//   DEFSM_CMD_O[3:0]       latched command (C/BE# inverted)
//   DEFSM_BUSY_O           high in every state except IDLE
//   DEFSM_ABORT_O          one-cycle pulse when a handler times out
//   DEFSM_STATE_O[2:0]     current FSM state, for debug and assertion binding
// ---------------------------------------------------------------------------
module pci_defsm_addr_decode #(
  parameter int BAR0_SIZE_LOG2 = 12,  // 4..31
  parameter int TIMEOUT_CYC    = 64   // 2..255
) (
  input  logic        PHY_CLK33_I,
  input  logic        PHY_RSTn_I,
  input  logic        INT_FRAMEn_I,
  input  logic        INT_IRDYn_I,
  input  logic        INT_IDSEL_I,
  input  logic [31:0] CFG_AD_I,
  input  logic [3:0]  CFG_CBEn_I,
  input  logic        CFG_REG_0x04_MEM_EN_I,
  input  logic [31:0] BAR0_BASE_I,
  output logic        DEFSM_ADD2INTMNG_O,
  input  logic        DEFSM_INTMNG_END_I,
  output logic        DEFSM_ADD2MEM_O,
  input  logic        DEFSM_MEM_END_I,
  output logic [31:0] DEFSM_ADDR_O,
  output logic [3:0]  DEFSM_CMD_O,
  output logic        DEFSM_BUSY_O,
  output logic        DEFSM_ABORT_O,
  output logic [2:0]  DEFSM_STATE_O
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_DECODE     = 3'd1;
  localparam logic [2:0] ST_WAIT_CFG   = 3'd2;
  localparam logic [2:0] ST_WAIT_MEM   = 3'd3;
  localparam logic [2:0] ST_IGNORE     = 3'd4;
  localparam logic [2:0] ST_TURNAROUND = 3'd5;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [2:0] state;
  logic       frame_q;
  logic       cfg_hit_q;
  logic       mem_hit_q;
  logic [7:0] tmo_cnt;

  logic [3:0] cmd;
  logic       addr_ev;
  logic       cfg_hit;
  logic       mem_hit;
  logic       bar_match;
  logic       bus_idle;

  // BAR0 bits below the window size are address offsets and never compared.
  logic       unused_bar_bits;
  assign unused_bar_bits = ^BAR0_BASE_I[BAR0_SIZE_LOG2-1:0];

  assign cmd      = ~CFG_CBEn_I;
  assign bus_idle = INT_FRAMEn_I && INT_IRDYn_I;

  // frame_q resets to 0, so a FRAME# already low when reset releases does
  // not look like a falling edge; FRAME# must be seen high first.
  assign addr_ev  = (state == ST_IDLE) && frame_q && !INT_FRAMEn_I;

  assign bar_match = (CFG_AD_I[31:BAR0_SIZE_LOG2] == BAR0_BASE_I[31:BAR0_SIZE_LOG2]);

  always_comb begin
    cfg_hit = 1'b0;
    mem_hit = 1'b0;
    // Type-0 config read/write: IDSEL asserted and AD[1:0] == 00.
    if ((cmd == 4'b1010 || cmd == 4'b1011) && INT_IDSEL_I && CFG_AD_I[1:0] == 2'b00)
      cfg_hit = 1'b1;
    // Memory read/write, read multiple, read line, write-and-invalidate.
    // DAC (1101) is deliberately absent.
    case (cmd)
      4'b0110, 4'b0111, 4'b1100, 4'b1110, 4'b1111:
        mem_hit = CFG_REG_0x04_MEM_EN_I && bar_match;
      default: mem_hit = 1'b0;
    endcase
  end

  always_ff @(posedge PHY_CLK33_I or negedge PHY_RSTn_I) begin
    if (!PHY_RSTn_I) begin
      state              <= ST_IDLE;
      frame_q            <= 1'b0;
      cfg_hit_q          <= 1'b0;
      mem_hit_q          <= 1'b0;
      tmo_cnt            <= 8'd0;
      DEFSM_ADDR_O       <= 32'd0;
      DEFSM_CMD_O        <= 4'd0;
      DEFSM_ADD2INTMNG_O <= 1'b0;
      DEFSM_ADD2MEM_O    <= 1'b0;
      DEFSM_ABORT_O      <= 1'b0;
    end else begin
      frame_q            <= INT_FRAMEn_I;
      // Pulses are high for one cycle only; they default low every cycle.
      DEFSM_ADD2INTMNG_O <= 1'b0;
      DEFSM_ADD2MEM_O    <= 1'b0;
      DEFSM_ABORT_O      <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (addr_ev) begin
            DEFSM_ADDR_O <= CFG_AD_I;
            DEFSM_CMD_O  <= cmd;
            cfg_hit_q    <= cfg_hit;
            mem_hit_q    <= mem_hit;
            state        <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          tmo_cnt <= 8'd0;
          if (cfg_hit_q) begin
            DEFSM_ADD2INTMNG_O <= 1'b1;
            state              <= ST_WAIT_CFG;
          end else if (mem_hit_q) begin
            DEFSM_ADD2MEM_O <= 1'b1;
            state           <= ST_WAIT_MEM;
          end else begin
            state <= ST_IGNORE;
          end
        end

        // An end pulse on the timeout cycle wins: no abort is raised.
        ST_WAIT_CFG: begin
          if (DEFSM_INTMNG_END_I) begin
            state <= ST_TURNAROUND;
          end else if (tmo_cnt == TMO_LAST) begin
            DEFSM_ABORT_O <= 1'b1;
            state         <= ST_TURNAROUND;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        ST_WAIT_MEM: begin
          if (DEFSM_MEM_END_I) begin
            state <= ST_TURNAROUND;
          end else if (tmo_cnt == TMO_LAST) begin
            DEFSM_ABORT_O <= 1'b1;
            state         <= ST_TURNAROUND;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        ST_IGNORE, ST_TURNAROUND: begin
          if (bus_idle)
            state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign DEFSM_BUSY_O  = (state != ST_IDLE);
  assign DEFSM_STATE_O = state;

endmodule
